id_pipe: RTL and testbench

ID_PIPE -- requirements
Module: id_pipe

---
 rtl/id_pipe_pkg.sv | 7 +
 rtl/id_pop_ctl.sv | 29 ++
 rtl/id_pipe.sv | 71 +++++++
 tb/tb_id_pipe.sv | 131 +++++++++++++
 4 files changed

// File: rtl/id_pipe_pkg.sv
// id_pipe_pkg: shared widths and the RUN/HOLD state encoding for the decode-register stage
package id_pipe_pkg;
  localparam int NCPU_INSN_DW = 32;
  localparam int FNT_EXC_W = 4;
  localparam int BPU_UPD_W = 8;
  typedef enum logic {S_RUN = 1'b0, S_HOLD = 1'b1} state_t;
endpackage

// File: rtl/id_pop_ctl.sv
// id_pop_ctl: leading-valid pop count truncated at the first faulting slot (valid, exc in; cnt, exc_hit out)
module id_pop_ctl
  import id_pipe_pkg::*;
#(
  parameter int P = 1,
  localparam int IW = 1 << P,
  localparam int CW = P + 1
) (
  input  logic [IW-1:0]                valid,
  input  logic [IW-1:0][FNT_EXC_W-1:0] exc,
  output logic [CW-1:0]                cnt,
  output logic                         exc_hit
);
  logic stop;
  always_comb begin
    cnt = '0;
    exc_hit = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < IW; i++) begin
      if (!stop && valid[i]) begin
        cnt = CW'(i + 1);
        exc_hit = |exc[i];
        stop = |exc[i];
      end else begin
        stop = 1'b1;
      end
    end
  end
endmodule

// File: rtl/id_pipe.sv
// id_pipe: IQ-to-decode register with exception hold; ports clk, rst (async active-low), flush, id_* in, id_pop_cnt, dec_* out, dec_ready, bubble_cnt; NCPU_ID_BUBBLE_CNT_EN enables the starvation counter
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int CONFIG_AW = 32,
  parameter int CONFIG_P_ISSUE_WIDTH = 1,
  localparam int IW = 1 << CONFIG_P_ISSUE_WIDTH,
  localparam int PC_W = CONFIG_AW - 2,
  localparam int CW = CONFIG_P_ISSUE_WIDTH + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [IW-1:0]                  id_valid,
  input  logic [IW-1:0][NCPU_INSN_DW-1:0] id_ins,
  input  logic [IW-1:0][PC_W-1:0]        id_pc,
  input  logic [IW-1:0][FNT_EXC_W-1:0]   id_exc,
  input  logic [IW-1:0][BPU_UPD_W-1:0]   id_bpu_upd,
  output logic [CW-1:0]                  id_pop_cnt,
  output logic [IW-1:0]                  dec_valid,
  output logic [IW-1:0][NCPU_INSN_DW-1:0] dec_ins,
  output logic [IW-1:0][PC_W-1:0]        dec_pc,
  output logic [IW-1:0][FNT_EXC_W-1:0]   dec_exc,
  output logic [IW-1:0][BPU_UPD_W-1:0]   dec_bpu_upd,
  input  logic                           dec_ready,
  output logic [31:0]                    bubble_cnt
);
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic exc_hit, empty, load;
  id_pop_ctl #(.P(CONFIG_P_ISSUE_WIDTH)) u_pop (
    .valid(id_valid),
    .exc(id_exc),
    .cnt(cnt),
    .exc_hit(exc_hit)
  );
  // rst is folded in so nothing is popped while the register is held in reset
  assign empty = ~|dec_valid;
  assign load = rst & ~flush & (state == S_RUN) & (empty | dec_ready);
  assign id_pop_cnt = load ? cnt : '0;
  always_comb begin
    state_nxt = flush ? S_RUN : (load & exc_hit) ? S_HOLD : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RUN;
      dec_valid <= '0;
      dec_ins <= '0;
      dec_pc <= '0;
      dec_exc <= '0;
      dec_bpu_upd <= '0;
    end else begin
      state <= state_nxt;
      dec_valid <= flush ? '0 : load ? ~({IW{1'b1}} << cnt) : dec_ready ? '0 : dec_valid;
      if (load) begin
        dec_ins <= id_ins;
        dec_pc <= id_pc;
        dec_exc <= id_exc;
        dec_bpu_upd <= id_bpu_upd;
      end
    end
  end
`ifdef NCPU_ID_BUBBLE_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bubble_cnt <= '0;
    else if (dec_ready & empty & ~flush & ~&bubble_cnt) bubble_cnt <= bubble_cnt + 32'd1;
  end
`else
  assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: directed self-checking bench for id_pipe at IW=2
module tb_id_pipe;
  import id_pipe_pkg::*;
`ifdef NCPU_ID_BUBBLE_CNT_EN
  localparam logic [31:0] BUB_EXP = 32'd10;
`else
  localparam logic [31:0] BUB_EXP = 32'd0;
`endif
  logic clk, rst, flush, dec_ready;
  logic [1:0] id_valid, dec_valid;
  logic [1:0][NCPU_INSN_DW-1:0] id_ins, dec_ins;
  logic [1:0][29:0] id_pc, dec_pc;
  logic [1:0][FNT_EXC_W-1:0] id_exc, dec_exc;
  logic [1:0][BPU_UPD_W-1:0] id_bpu_upd, dec_bpu_upd;
  logic [1:0] id_pop_cnt;
  logic [31:0] bubble_cnt;
  int n_cmp = 0, n_bad = 0;
  id_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ins(id_ins), .id_pc(id_pc), .id_exc(id_exc), .id_bpu_upd(id_bpu_upd),
    .id_pop_cnt(id_pop_cnt),
    .dec_valid(dec_valid), .dec_ins(dec_ins), .dec_pc(dec_pc), .dec_exc(dec_exc), .dec_bpu_upd(dec_bpu_upd),
    .dec_ready(dec_ready), .bubble_cnt(bubble_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    rst = 1'b0;
    flush = 1'b0;
    dec_ready = 1'b0;
    id_valid = 2'b11;
    id_ins = {32'hBBBB_0002, 32'hAAAA_0001};
    id_pc = {30'h104, 30'h100};
    id_exc = '0;
    id_bpu_upd = {8'h22, 8'h11};
    #3;
    chk("rst_pop", 64'(id_pop_cnt), 64'd0);
    chk("rst_valid", 64'(dec_valid), 64'd0);
    chk("rst_bubble", 64'(bubble_cnt), 64'd0);
    chk("rst_pc", 64'(dec_pc), 64'd0);
    id_valid = 2'b00;
    dec_ready = 1'b1;
    #19 rst = 1'b1;
    repeat (10) step;
    chk("bubble10", 64'(bubble_cnt), 64'(BUB_EXP));
    chk("empty_load", 64'(dec_valid), 64'd0);
    id_valid = 2'b11;
    #1 chk("pop2", 64'(id_pop_cnt), 64'd2);
    step;
    chk("load_valid", 64'(dec_valid), 64'd3);
    chk("load_pc", 64'(dec_pc), {4'h0, 30'h104, 30'h100});
    chk("load_ins", 64'(dec_ins), 64'hBBBB_0002_AAAA_0001);
    chk("load_bpu", 64'(dec_bpu_upd), 64'h2211);
    dec_ready = 1'b0;
    id_pc = {30'h208, 30'h204};
    id_ins = {32'hDDDD_0004, 32'hCCCC_0003};
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_pop", 64'(id_pop_cnt), 64'd0);
      step;
      chk("stall_valid", 64'(dec_valid), 64'd3);
      chk("stall_pc", 64'(dec_pc), {4'h0, 30'h104, 30'h100});
    end
    dec_ready = 1'b1;
    id_exc = {4'h0, 4'h3};
    #1 chk("exc0_pop", 64'(id_pop_cnt), 64'd1);
    step;
    chk("exc0_valid", 64'(dec_valid), 64'd1);
    chk("exc0_exc", 64'(dec_exc[0]), 64'd3);
    chk("exc0_pc", 64'(dec_pc[0]), 64'h204);
    id_exc = '0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("hold_pop", 64'(id_pop_cnt), 64'd0);
      step;
    end
    chk("hold_valid", 64'(dec_valid), 64'd0);
    flush = 1'b1;
    #1 chk("flush_pop", 64'(id_pop_cnt), 64'd0);
    step;
    flush = 1'b0;
    #1 chk("post_flush_pop", 64'(id_pop_cnt), 64'd2);
    step;
    chk("post_flush_valid", 64'(dec_valid), 64'd3);
    id_exc = {4'h5, 4'h0};
    #1 chk("exc1_pop", 64'(id_pop_cnt), 64'd2);
    step;
    chk("exc1_valid", 64'(dec_valid), 64'd3);
    chk("exc1_exc", 64'(dec_exc), 64'h50);
    id_exc = '0;
    #1 chk("exc1_hold_pop", 64'(id_pop_cnt), 64'd0);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("flush_clear", 64'(dec_valid), 64'd0);
    id_valid = 2'b01;
    #1 chk("one_pop", 64'(id_pop_cnt), 64'd1);
    step;
    chk("one_valid", 64'(dec_valid), 64'd1);
    id_valid = 2'b11;
    flush = 1'b1;
    #1 chk("flush_rdy_pop", 64'(id_pop_cnt), 64'd0);
    step;
    flush = 1'b0;
    chk("flush_rdy_valid", 64'(dec_valid), 64'd0);
    #1 chk("refill_pop", 64'(id_pop_cnt), 64'd2);
    step;
    chk("refill_valid", 64'(dec_valid), 64'd3);
    dec_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_valid", 64'(dec_valid), 64'd0);
    chk("async_bubble", 64'(bubble_cnt), 64'd0);
    chk("async_pop", 64'(id_pop_cnt), 64'd0);
    chk("async_pc", 64'(dec_pc), 64'd0);
    #3 rst = 1'b1;
    step;
    chk("resume_valid", 64'(dec_valid), 64'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
